// File: rtl/dmem_pkg.sv
// Shared types and encodings for the data-memory responder.
// Misalignment trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // Instr27_26 op classes
    localparam logic [1:0] OpExtra    = 2'b00;
    localparam logic [1:0] OpWordByte = 2'b01;

    // Instr6_5 extra-transfer types
    localparam logic [1:0] ExtNone  = 2'b00;
    localparam logic [1:0] ExtHalfU = 2'b01;
    localparam logic [1:0] ExtByteS = 2'b10;
    localparam logic [1:0] ExtHalfS = 2'b11;

    typedef enum logic [2:0] {
        LdNone  = 3'd0,
        LdWord  = 3'd1,
        LdByteU = 3'd2,
        LdHalfU = 3'd3,
        LdByteS = 3'd4,
        LdHalfS = 3'd5
    } load_type_e;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  be;
        logic [1:0]  cls;
        logic [1:0]  ext;
        logic [31:0] wdata;
    } req_t;

    function automatic load_type_e decode_load(input logic [1:0] cls, input logic [1:0] ext,
                                               input logic [3:0] be);
        load_type_e t;
        t = LdNone;
        if (cls == OpWordByte) begin
            if (be == 4'b1111) begin
                t = LdWord;
            end else if (be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000}) begin
                t = LdByteU;
            end
        end else if (cls == OpExtra) begin
            case (ext)
                ExtHalfU: t = LdHalfU;
                ExtByteS: t = LdByteS;
                ExtHalfS: t = LdHalfS;
                default:  t = LdNone;
            endcase
        end
        return t;
    endfunction

    // Any encoding that is neither a load nor a store is a no-op.
    function automatic logic is_valid_op(input logic [1:0] cls, input logic [1:0] ext);
        return (cls == OpWordByte) || ((cls == OpExtra) && (ext != ExtNone));
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Core-to-data-memory bus; err exists only when DMEM_MISALIGN_TRAP_EN is defined.
interface dmem_if;
    logic        req;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  byteEnable;
    logic [1:0]  Instr27_26;
    logic [1:0]  Instr6_5;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        err;
`endif

    modport master (
        output req, we, adr, byteEnable, Instr27_26, Instr6_5, wdata,
        input  ready, rdata
`ifdef DMEM_MISALIGN_TRAP_EN
        , input err
`endif
    );

    modport slave (
        input  req, we, adr, byteEnable, Instr27_26, Instr6_5, wdata,
        output ready, rdata
`ifdef DMEM_MISALIGN_TRAP_EN
        , output err
`endif
    );
endinterface

// File: rtl/load_extend.sv
// Selects the addressed lane of a memory word and zero/sign-extends it.
module load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  load_type_e  type_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = word_i >> {offset_i, 3'b000};

    always_comb begin
        data_o = '0;
        unique case (type_i)
            LdWord:  data_o = word_i;
            LdByteU: data_o = {24'b0, shifted[7:0]};
            LdHalfU: data_o = {16'b0, shifted[15:0]};
            LdByteS: data_o = {{24{shifted[7]}}, shifted[7:0]};
            LdHalfS: data_o = {{16{shifted[15]}}, shifted[15:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder with byte-lane stores and extending loads.
// Optional misalignment trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic   clk,
    input logic   reset,
    dmem_if.slave bus
);

    localparam int unsigned AdrW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WaitCnt = 4'(WAIT_STATES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;

    logic [31:0]     mem_q [DEPTH_WORDS];
    logic [AdrW-1:0] widx;
    logic [31:0]     rd_word;
    logic [31:0]     ext_data;
    load_type_e      ld_type;
    logic            wr_block;
    logic            wr_en;
    logic            unused_adr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    req_d = '{we:    bus.we,
                              adr:   bus.adr,
                              be:    bus.byteEnable,
                              cls:   bus.Instr27_26,
                              ext:   bus.Instr6_5,
                              wdata: bus.wdata};
                    cnt_d   = '0;
                    state_d = (WaitCnt == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_d == WaitCnt) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                // A req held through RESP is picked up on the following IDLE cycle.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // High address bits wrap onto the storage array.
    assign widx       = req_q.adr[AdrW+1:2];
    assign unused_adr = ^req_q.adr[31:AdrW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign;

    always_comb begin
        misalign = 1'b0;
        if ((req_q.cls == OpExtra) && ((req_q.ext == ExtHalfU) || (req_q.ext == ExtHalfS))) begin
            misalign = req_q.adr[0];
        end else if ((req_q.cls == OpWordByte) && (req_q.be == 4'b1111)) begin
            misalign = (req_q.adr[1:0] != 2'b00);
        end
    end

    assign wr_block = misalign;
    assign bus.err  = (state_q == RESP) && misalign;
`else
    assign wr_block = 1'b0;
`endif

    assign wr_en = (state_q == RESP) && req_q.we && is_valid_op(req_q.cls, req_q.ext) && !wr_block;

    // Storage is deliberately not reset; an abandoned request never reaches RESP.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (req_q.be[i]) begin
                    mem_q[widx][8*i +: 8] <= req_q.wdata[8*i +: 8];
                end
            end
        end
    end

    assign rd_word = mem_q[widx];
    assign ld_type = req_q.we ? LdNone : decode_load(req_q.cls, req_q.ext, req_q.be);

    load_extend u_load_extend (
        .word_i   (rd_word),
        .offset_i (req_q.adr[1:0]),
        .type_i   (ld_type),
        .data_o   (ext_data)
    );

    assign bus.ready = (state_q == RESP);
    assign bus.rdata = (state_q == RESP) ? ext_data : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (WAIT_STATES=2, DEPTH_WORDS=64).
// Extra err checks are compiled in when DMEM_MISALIGN_TRAP_EN is defined.
module tb_dmem_responder;
    import dmem_pkg::*;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    dmem_if bus ();

    dmem_responder #(
        .DEPTH_WORDS (64),
        .WAIT_STATES (2)
    ) dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // One transaction; inputs are scrambled after the accept edge to prove they were latched.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] be,
                        input logic [1:0] cls, input logic [1:0] ext, input logic [31:0] wdata,
                        output logic [31:0] rd, output int lat, output logic e, output logic seen);
        bus.req        = 1'b1;
        bus.we         = we;
        bus.adr        = adr;
        bus.byteEnable = be;
        bus.Instr27_26 = cls;
        bus.Instr6_5   = ext;
        bus.wdata      = wdata;
        @(posedge clk);
        #1;
        bus.we         = ~we;
        bus.adr        = ~adr;
        bus.byteEnable = ~be;
        bus.Instr27_26 = ~cls;
        bus.Instr6_5   = ~ext;
        bus.wdata      = ~wdata;
        lat  = 0;
        rd   = '0;
        e    = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (bus.ready) begin
                seen = 1'b1;
                rd   = bus.rdata;
`ifdef DMEM_MISALIGN_TRAP_EN
                e    = bus.err;
`endif
            end
        end
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        @(negedge clk);
        check("ready_one_cycle", {31'b0, bus.ready}, 32'h0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  be;
        logic [1:0]  cls;
        logic [1:0]  ext;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    localparam int NumVecs = 21;
    vec_t vecs [NumVecs];

    initial begin
        logic [31:0] rd;
        int          lat;
        int          gap;
        int          pulses;
        logic        e;
        logic        seen;

        vecs[0]  = '{1'b1, 32'h10,       4'hF, 2'b01, 2'b00, 32'hDEADBEEF, 32'h0,        1'b0, "st_word"};
        vecs[1]  = '{1'b0, 32'h10,       4'hF, 2'b01, 2'b00, 32'h0,        32'hDEADBEEF, 1'b0, "ld_word"};
        vecs[2]  = '{1'b1, 32'h10,       4'hF, 2'b01, 2'b00, 32'h80FF7F01, 32'h0,        1'b0, "st_word2"};
        vecs[3]  = '{1'b0, 32'h13,       4'h8, 2'b00, 2'b10, 32'h0,        32'hFFFFFF80, 1'b0, "ld_sbyte3"};
        vecs[4]  = '{1'b0, 32'h12,       4'hC, 2'b00, 2'b01, 32'h0,        32'h000080FF, 1'b0, "ld_uhalf2"};
        vecs[5]  = '{1'b0, 32'h12,       4'hC, 2'b00, 2'b11, 32'h0,        32'hFFFF80FF, 1'b0, "ld_shalf2"};
        vecs[6]  = '{1'b0, 32'h10,       4'h3, 2'b00, 2'b11, 32'h0,        32'h00007F01, 1'b0, "ld_shalf0"};
        vecs[7]  = '{1'b0, 32'h11,       4'h2, 2'b01, 2'b00, 32'h0,        32'h0000007F, 1'b0, "ld_ubyte1"};
        vecs[8]  = '{1'b0, 32'h10,       4'h1, 2'b00, 2'b10, 32'h0,        32'h00000001, 1'b0, "ld_sbyte0"};
        vecs[9]  = '{1'b1, 32'h20,       4'hF, 2'b01, 2'b00, 32'h11223344, 32'h0,        1'b0, "st_w20"};
        vecs[10] = '{1'b1, 32'h20,       4'h2, 2'b01, 2'b00, 32'hAAAAAAAA, 32'h0,        1'b0, "st_byte1"};
        vecs[11] = '{1'b0, 32'h20,       4'hF, 2'b01, 2'b00, 32'h0,        32'h1122AA44, 1'b0, "ld_after_byte"};
        vecs[12] = '{1'b1, 32'h20,       4'hF, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h0,        1'b0, "st_noop"};
        vecs[13] = '{1'b0, 32'h20,       4'hF, 2'b01, 2'b00, 32'h0,        32'h1122AA44, 1'b0, "ld_after_noop"};
        vecs[14] = '{1'b0, 32'h20,       4'hF, 2'b11, 2'b00, 32'h0,        32'h0,        1'b0, "ld_unlisted"};
        vecs[15] = '{1'b1, 32'h100,      4'hF, 2'b01, 2'b00, 32'h0BADF00D, 32'h0,        1'b0, "st_alias"};
        vecs[16] = '{1'b0, 32'h0,        4'hF, 2'b01, 2'b00, 32'h0,        32'h0BADF00D, 1'b0, "ld_alias0"};
        vecs[17] = '{1'b0, 32'hFFFFFF00, 4'hF, 2'b01, 2'b00, 32'h0,        32'h0BADF00D, 1'b0, "ld_alias_hi"};
        vecs[18] = '{1'b1, 32'h22,       4'hC, 2'b00, 2'b01, 32'h55665566, 32'h0,        1'b0, "st_half2"};
        vecs[19] = '{1'b0, 32'h20,       4'hF, 2'b01, 2'b00, 32'h0,        32'h5566AA44, 1'b0, "ld_after_half"};
        vecs[20] = '{1'b0, 32'h11,       4'h6, 2'b00, 2'b01, 32'h0,        32'h0000FF7F, TrapEn, "ld_mis_half"};

        bus.req        = 1'b0;
        bus.we         = 1'b0;
        bus.adr        = '0;
        bus.byteEnable = '0;
        bus.Instr27_26 = '0;
        bus.Instr6_5   = '0;
        bus.wdata      = '0;

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, bus.ready}, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("rst_err", {31'b0, bus.err}, 32'h0);
`endif
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NumVecs; i++) begin
            xfer(vecs[i].we, vecs[i].adr, vecs[i].be, vecs[i].cls, vecs[i].ext, vecs[i].wdata,
                 rd, lat, e, seen);
            check($sformatf("%s_ready", vecs[i].name), {31'b0, seen}, 32'h1);
            check($sformatf("%s_latency", vecs[i].name), lat, 32'd3);
            check($sformatf("%s_rdata", vecs[i].name), rd, vecs[i].exp_rdata);
`ifdef DMEM_MISALIGN_TRAP_EN
            check($sformatf("%s_err", vecs[i].name), {31'b0, e}, {31'b0, vecs[i].exp_err});
`endif
        end

        // Reset while a store sits in WAIT: no response, no write, next request fine.
        xfer(1'b1, 32'h30, 4'hF, 2'b01, 2'b00, 32'h55667788, rd, lat, e, seen);
        bus.req        = 1'b1;
        bus.we         = 1'b1;
        bus.adr        = 32'h30;
        bus.byteEnable = 4'hF;
        bus.Instr27_26 = 2'b01;
        bus.Instr6_5   = 2'b00;
        bus.wdata      = 32'hFFFFFFFF;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_ready_async", {31'b0, bus.ready}, 32'h0);
        check("abort_rdata_async", bus.rdata, 32'h0);
        bus.req = 1'b0;
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.ready) pulses++;
        end
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.ready) pulses++;
        end
        check("abort_no_ready", pulses, 32'd0);
        xfer(1'b0, 32'h30, 4'hF, 2'b01, 2'b00, 32'h0, rd, lat, e, seen);
        check("abort_mem_kept", rd, 32'h55667788);
        check("abort_next_latency", lat, 32'd3);

        // req held through RESP is taken only on the following IDLE cycle.
        bus.req        = 1'b1;
        bus.we         = 1'b0;
        bus.adr        = 32'h10;
        bus.byteEnable = 4'hF;
        bus.Instr27_26 = 2'b01;
        bus.Instr6_5   = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus.ready;
        end
        check("b2b_first_ready", {31'b0, seen}, 32'h1);
        gap  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            gap++;
            if (bus.ready) begin
                seen = 1'b1;
                rd   = bus.rdata;
            end
        end
        check("b2b_gap", gap, 32'd4);
        check("b2b_rdata", rd, 32'h80FF7F01);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        @(negedge clk);

`ifdef DMEM_MISALIGN_TRAP_EN
        // Misaligned halfword store is flagged and not written.
        xfer(1'b1, 32'h21, 4'h6, 2'b00, 2'b01, 32'hBBBBBBBB, rd, lat, e, seen);
        check("mis_st_err", {31'b0, e}, 32'h1);
        check("mis_st_latency", lat, 32'd3);
        xfer(1'b0, 32'h20, 4'hF, 2'b01, 2'b00, 32'h0, rd, lat, e, seen);
        check("mis_st_mem", rd, 32'h5566AA44);
        check("mis_st_rd_err", {31'b0, e}, 32'h0);
        xfer(1'b0, 32'h22, 4'hF, 2'b01, 2'b00, 32'h0, rd, lat, e, seen);
        check("mis_word_err", {31'b0, e}, 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
